dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
Two-port access controller in front of the 4 KB word-organised data memory (dm_4k). It arbitrates between port 0 (CPU load/store) and port 1 (DMA/debug loader) using round-robin. It sequences each granted access onto the single memory port. Byte stores become a read-modify-write, because the memory only writes whole words.

Parameters:
ADDR_W, 12, byte-address width (memory word index = addr[ADDR_W-1:2])
DATA_W, 32, data width; fixed at 32, byte lanes assumed

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
pN_req  in  1  port N (N=0,1) request; held high until pN_ack
pN_we  in  1  1=store, 0=load; stable while pN_req high
pN_byte  in  1  1=byte access (lb/sb), 0=word access
pN_addr  in  ADDR_W  byte address; stable while pN_req high
pN_wdata  in  32  store data; only [7:0] is used when pN_byte=1
pN_ack  out  1  one-cycle completion pulse, registered
pN_rdata  out  32  load result; valid from the pN_ack cycle, held until the next port-N load completes
mem_addr  out  ADDR_W-2  word address to memory
mem_din  out  32  write data to memory
mem_we  out  1  memory write enable; memory writes on the rising edge
mem_lb  out  1  selects the memory's sign-extended byte read
mem_lbsel  out  2  byte-lane select for mem_lb
mem_dout  in  32  combinational read data from memory
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n=0, asynchronous) forces the following:
  - state=IDLE, rr_ptr=0;
  - all pN_ack=0 and all pN_rdata=0;
  - all latched request fields cleared.
  - mem_we, mem_lb, mem_lbsel, mem_addr and mem_din are decoded from state, so each drops to 0 as soon as reset asserts. No write is issued for an aborted operation.
- States: IDLE, ACCESS, RMW_WR.
- IDLE:
  - Outputs: mem_* = 0 and busy=0.
  - Eligible port N: pN_req=1 and pN_ack=0. A port is masked in its own ack cycle so the same request is never re-accepted.
  - One port eligible: grant it.
  - Both ports eligible: grant port rr_ptr; then rr_ptr <= the other port.
  - Single grant: rr_ptr <= the non-granted port.
  - On grant: latch the port id, we, byte, addr and wdata; go to ACCESS.
- ACCESS (exactly 1 cycle); mem_addr = latched addr[ADDR_W-1:2] in all cases:
  - Load: mem_lb=byte and mem_lbsel=addr[1:0]. Capture mem_dout into the granted pN_rdata. pN_ack=1 on the next cycle; go to IDLE.
  - Word store: mem_we=1, mem_din=wdata. pN_ack=1 on the next cycle; go to IDLE.
  - Byte store: mem_lb=0 and mem_we=0. Capture mem_dout into the internal merge register; go to RMW_WR.
- RMW_WR (1 cycle):
  - mem_addr is unchanged and mem_we=1.
  - mem_din = merge word with lane addr[1:0] replaced by wdata[7:0]. Lane 0 = bits [7:0], lane 3 = bits [31:24].
  - pN_ack=1 on the next cycle; go to IDLE.
- Latency from pN_req seen in IDLE to pN_ack: load 2 cycles, word store 2 cycles, byte store 3 cycles.
- pN_ack is a single-cycle pulse. Stores never modify pN_rdata.
- A new grant may be made in the same IDLE cycle in which the other port's ack is high (back-to-back, no bubble).
- Byte load sign extension is done by the memory. The arbiter passes mem_dout through unmodified.
- pN_req dropped before ack (protocol violation): the latched operation still completes and acks.
- An address at the top of memory (0xFFF) needs no special case; there is no wrap-around handling.

Test Plan:
- Reset mid RMW: assert rst_n=0 while in RMW_WR -> mem_we=0 immediately, the memory word is unchanged, and pN_ack/pN_rdata=0.
- Word load: preload word[5]=0x8040_20F0; p0 load, word, addr=0x014 -> p0_ack 2 cycles after req, p0_rdata=0x8040_20F0.
- Byte load with sign: same word; p0 byte load at addr=0x017 -> p0_rdata=0xFFFF_FF80. At addr=0x016 -> 0x0000_0040.
- Byte store RMW: word[5]=0x1122_3344; p1 sb wdata=0xAB at addr=0x015 -> 1 read cycle then 1 write cycle; word[5]=0x1122_AB44; p1_ack 3 cycles after req.
- Contention and round-robin: both ports hold word stores continuously for 4 grants -> grant order p0,p1,p0,p1. No idle cycle between an ack and the next ACCESS beyond the IDLE grant cycle. Neither port is granted twice per ack.
- Ack masking: p0 keeps req high for one cycle after its ack while p1 is idle -> p0 is not re-granted in the ack cycle; it is granted the following cycle.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Two-port round-robin access controller in front of the word-organised data memory.
// Sequences each granted access onto the single memory port; byte stores become a read-modify-write.
module dm_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_byte,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_byte,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,

  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              mem_lb,
  output logic [1:0]        mem_lbsel,
  input  logic [DATA_W-1:0] mem_dout,

  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RMW_WR = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic                byte_q, byte_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   merge_q, merge_d;
  logic [1:0]          ack_q, ack_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;

  logic [1:0]          elig;
  logic                gnt;
  logic [DATA_W-1:0]   merged;

  // A port is masked during its own ack cycle so a held request is not taken twice.
  assign elig = {p1_req & ~ack_q[1], p0_req & ~ack_q[0]};

  always_comb begin
    merged = merge_q;
    merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      ack_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      port_q   <= port_d;
      we_q     <= we_d;
      byte_q   <= byte_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      ack_q    <= ack_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    port_d   = port_q;
    we_d     = we_q;
    byte_d   = byte_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    ack_d    = '0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          gnt     = (&elig) ? rr_q : elig[1];
          port_d  = gnt;
          rr_d    = ~gnt;
          we_d    = gnt ? p1_we    : p0_we;
          byte_d  = gnt ? p1_byte  : p0_byte;
          addr_d  = gnt ? p1_addr  : p0_addr;
          wdata_d = gnt ? p1_wdata : p0_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q && byte_q) begin
          merge_d = mem_dout;
          state_d = RMW_WR;
        end else begin
          if (!we_q) begin
            if (port_q) rdata1_d = mem_dout;
            else        rdata0_d = mem_dout;
          end
          ack_d[port_q] = 1'b1;
          state_d       = IDLE;
        end
      end
      RMW_WR: begin
        ack_d[port_q] = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs are decoded from state only, so reset silences them at once.
  always_comb begin
    mem_addr  = '0;
    mem_din   = '0;
    mem_we    = 1'b0;
    mem_lb    = 1'b0;
    mem_lbsel = 2'b00;
    busy      = (state_q != IDLE);

    unique case (state_q)
      ACCESS: begin
        mem_addr = addr_q[ADDR_W-1:2];
        if (!we_q) begin
          mem_lb    = byte_q;
          mem_lbsel = addr_q[1:0];
        end else if (!byte_q) begin
          mem_we  = 1'b1;
          mem_din = wdata_q;
        end
      end
      RMW_WR: begin
        mem_addr = addr_q[ADDR_W-1:2];
        mem_we   = 1'b1;
        mem_din  = merged;
      end
      default: ;
    endcase
  end

  assign p0_ack   = ack_q[0];
  assign p1_ack   = ack_q[1];
  assign p0_rdata = rdata0_q;
  assign p1_rdata = rdata1_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: a behavioural memory, a per-port reference model
// that predicts each response at issue time, and a monitor that checks every ack.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic [1:0]  req, we, bt;
  logic [11:0] addr  [2];
  logic [31:0] wdata [2];
  logic        p0_ack, p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        mem_we, mem_lb;
  logic [1:0]  mem_lbsel;
  logic        busy;
  logic [1:0]  ack;
  assign ack = {p1_ack, p0_ack};

  dm_port_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(req[0]), .p0_we(we[0]), .p0_byte(bt[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(req[1]), .p1_we(we[1]), .p1_byte(bt[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_lb(mem_lb),
    .mem_lbsel(mem_lbsel), .mem_dout(mem_dout), .busy(busy)
  );

  // Behavioural memory: combinational read with optional sign-extended byte, write on rising edge.
  logic [31:0] mem [1024];
  logic        pre_en = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  always_comb begin
    rd_word  = mem[mem_addr];
    rd_byte  = 8'(rd_word >> {mem_lbsel, 3'b000});
    mem_dout = mem_lb ? {{24{rd_byte[7]}}, rd_byte} : rd_word;
  end
  always @(posedge clk) begin
    if (mem_we)      mem[mem_addr] <= mem_din;
    else if (pre_en) mem[pre_addr] <= pre_data;
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int npass = 0, ntot = 0;
  logic [31:0] ref_mem  [1024];
  logic [31:0] ref_last [2];
  logic [31:0] expq0[$], expq1[$];
  int          log_port[$], log_cyc[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_lb(logic [31:0] word, int lane);
    int v;
    v = int'((word >> (8 * lane)) & 32'hFF);
    if (v >= 128) v = v - 256;
    return 32'(v);
  endfunction

  task automatic preload(int a, logic [31:0] d);
    pre_en = 1'b1; pre_addr = 10'(a); pre_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Predict the response from the port's view of memory, queue it, then drive the request.
  task automatic start_req(int p, bit w, bit b, logic [11:0] a, logic [31:0] d);
    int wi   = int'(a[11:2]);
    int lane = int'(a[1:0]);
    logic [31:0] exp;
    if (!w) begin
      exp = b ? ref_lb(ref_mem[wi], lane) : ref_mem[wi];
      ref_last[p] = exp;
    end else begin
      if (b) ref_mem[wi] = (ref_mem[wi] & ~(32'hFF << (8 * lane))) | ({24'h0, d[7:0]} << (8 * lane));
      else   ref_mem[wi] = d;
      exp = ref_last[p];
    end
    if (p == 0) expq0.push_back(exp);
    else        expq1.push_back(exp);
    req[p] = 1'b1; we[p] = w; bt[p] = b; addr[p] = a; wdata[p] = d;
  endtask

  task automatic wait_ack(int p, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ack[p] && cyc < 50);
    if (!ack[p]) begin
      ntot++;
      $display("FAIL ack_timeout port%0d: got no ack expected ack within 50 cycles", p);
    end
  endtask

  task automatic drop_req(int p);
    req[p] = 1'b0;
  endtask

  task automatic do_op(int p, bit w, bit b, logic [11:0] a, logic [31:0] d, int exp_lat);
    int c;
    start_req(p, w, b, a, d);
    wait_ack(p, c);
    drop_req(p);
    if (exp_lat > 0) check($sformatf("latency_p%0d_%03h", p, a), c, exp_lat);
    @(negedge clk);
  endtask

  task automatic rand_port(int p, int n);
    bit w, b;
    logic [11:0] a;
    int c;
    for (int i = 0; i < n; i++) begin
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      a = (p == 1) ? 12'h800 + 12'($urandom_range(0, 2047)) : 12'($urandom_range(0, 1023));
      if (!b) a[1:0] = 2'b00;
      start_req(p, w, b, a, $urandom);
      wait_ack(p, c);
      drop_req(p);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // Monitor: every ack must be a single-cycle pulse matching the oldest prediction for its port.
  logic [1:0] prev_ack = '0;
  always @(negedge clk) begin
    if (!rst_n) prev_ack = '0;
    else begin
      for (int p = 0; p < 2; p++) begin
        if (ack[p]) begin
          check($sformatf("ack_pulse_p%0d", p), 32'(prev_ack[p]), 32'd0);
          if ((p == 0 && expq0.size() == 0) || (p == 1 && expq1.size() == 0)) begin
            ntot++;
            $display("FAIL spurious_ack_p%0d: got ack expected none outstanding", p);
          end else if (p == 0) check("rdata_p0", p0_rdata, expq0.pop_front());
          else                 check("rdata_p1", p1_rdata, expq1.pop_front());
          log_port.push_back(p);
          log_cyc.push_back(cyc_cnt);
        end
      end
      prev_ack = ack;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, bad;
    rst_n = 1'b0;
    req = '0; we = '0; bt = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    ref_last[0] = '0; ref_last[1] = '0;
    repeat (3) @(negedge clk);
    check("rst_p0_ack", 32'(p0_ack), 0);
    check("rst_p1_ack", 32'(p1_ack), 0);
    check("rst_p0_rdata", p0_rdata, 0);
    check("rst_p1_rdata", p1_rdata, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 1024; i++) preload(i, $urandom);

    // Word and sign-extended byte loads.
    preload(5, 32'h8040_20F0);
    do_op(0, 0, 0, 12'h014, 0, 2);
    do_op(0, 0, 1, 12'h017, 0, 2);
    do_op(0, 0, 1, 12'h016, 0, 2);

    // Byte store read-modify-write.
    preload(5, 32'h1122_3344);
    do_op(1, 1, 1, 12'h015, 32'h0000_00AB, 3);
    check("rmw_word5", mem[5], 32'h1122_AB44);
    do_op(0, 1, 0, 12'h018, 32'hDEAD_BEEF, 2);

    // Top of memory.
    do_op(1, 1, 1, 12'hFFF, 32'h0000_00C3, 3);
    do_op(1, 0, 1, 12'hFFF, 0, 2);
    do_op(1, 0, 0, 12'hFFC, 0, 2);

    // Held request across its own ack: masked in the ack cycle, granted the next.
    start_req(0, 0, 0, 12'h020, 0);
    wait_ack(0, c);
    check("mask_first_latency", c, 2);
    start_req(0, 0, 0, 12'h024, 0);
    @(negedge clk);
    check("mask_no_regrant", 32'(busy), 0);
    @(negedge clk);
    check("mask_granted_next", 32'(busy), 1);
    check("mask_addr", 32'(mem_addr), 32'h9);
    wait_ack(0, c);
    check("mask_second_latency", c, 1);
    drop_req(0);
    @(negedge clk);

    // Reset asserted while the write half of a byte store is on the bus.
    preload(7, 32'hCAFE_1234);
    req[1] = 1'b1; we[1] = 1'b1; bt[1] = 1'b1; addr[1] = 12'h01D; wdata[1] = 32'h77;
    @(negedge clk);
    check("rmw_read_we", 32'(mem_we), 0);
    check("rmw_read_addr", 32'(mem_addr), 7);
    @(negedge clk);
    check("rmw_write_we", 32'(mem_we), 1);
    check("rmw_write_din", mem_din, 32'hCAFE_7734);
    rst_n = 1'b0;
    #1;
    check("abort_mem_we", 32'(mem_we), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_p1_ack", 32'(p1_ack), 0);
    check("abort_p1_rdata", p1_rdata, 0);
    check("abort_p0_rdata", p0_rdata, 0);
    req = '0;
    expq0.delete(); expq1.delete();
    ref_last[0] = '0; ref_last[1] = '0;
    @(posedge clk);
    @(negedge clk);
    check("abort_word7", mem[7], 32'hCAFE_1234);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention straight after reset: alternating grants, one ack every two cycles.
    log_port.delete(); log_cyc.delete();
    fork
      begin
        int c0;
        start_req(0, 1, 0, 12'h100, $urandom);
        wait_ack(0, c0);
        start_req(0, 1, 0, 12'h104, $urandom);
        wait_ack(0, c0);
        drop_req(0);
      end
      begin
        int c1;
        start_req(1, 1, 0, 12'h900, $urandom);
        wait_ack(1, c1);
        start_req(1, 1, 0, 12'h904, $urandom);
        wait_ack(1, c1);
        drop_req(1);
      end
    join
    @(negedge clk);
    check("rr_ack_count", log_port.size(), 4);
    if (log_port.size() >= 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("rr_order_%0d", i), log_port[i], i % 2);
      for (int i = 1; i < 4; i++) check($sformatf("rr_gap_%0d", i), log_cyc[i] - log_cyc[i-1], 2);
    end

    // Randomised traffic; the ports use disjoint halves of memory.
    fork
      rand_port(0, 60);
      rand_port(1, 60);
    join
    repeat (3) @(negedge clk);
    check("queue0_drained", expq0.size(), 0);
    check("queue1_drained", expq1.size(), 0);

    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_image_bad_words", bad, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
